// File: rtl/serial_add_sub.sv
// Digit-serial add/subtract: out = a + b (control=0) or a - b (control=1), DIGIT bits per cycle; define SERIAL_ADD_SUB_SAT_EN to clamp on signed overflow.
// Latency: out_valid rises WIDTH/DIGIT edges after the accepting edge; one op per WIDTH/DIGIT+2 cycles at best.
// Backpressure: result, cout and ovf hold in DONE until out_ready; in_ready stays low until the result is taken.
module serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_sh, b_sh, acc;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic [DIGIT:0]     slice;
    logic               msb_cin;
    logic               last;
    logic               raw_ovf;
    logic [WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]   res_final;

    assign slice   = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    // Carry into the slice MSB recovered from the sum bit; only meaningful on the final digit.
    assign msb_cin = slice[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
    assign raw_ovf = msb_cin ^ slice[DIGIT];
    assign last    = (cnt == CNT_W'(N - 1));
    assign acc_nxt = (acc >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));

`ifdef SERIAL_ADD_SUB_SAT_EN
    // On the final digit a_sh[DIGIT-1] is the original sign of A.
    always_comb begin
        res_final = acc_nxt;
        if (raw_ovf) begin
            res_final = a_sh[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign res_final = acc_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CALC;
            CALC:    if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            out   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_sh  <= a;
            b_sh  <= b ^ {WIDTH{control}};
            carry <= control;
            cnt   <= '0;
        end else if (state == CALC) begin
            a_sh  <= a_sh >> DIGIT;
            b_sh  <= b_sh >> DIGIT;
            acc   <= acc_nxt;
            carry <= slice[DIGIT];
            cnt   <= cnt + CNT_W'(1);
            if (last) begin
                out  <= res_final;
                cout <= slice[DIGIT];
                ovf  <= raw_ovf;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: three instances (DIGIT 1, 4, 16) share stimulus; directed vectors plus model-checked random ops.
module tb_serial_add_sub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a, b;
    logic        control;
    logic        out_ready;

    logic        rdy [3];
    logic        vld [3];
    logic [15:0] res [3];
    logic        co  [3];
    logic        ov  [3];

    int n_cmp = 0;
    int n_mis = 0;
    int lat_exp [3] = '{16, 4, 1};

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .a(a), .b(b),
        .control(control), .out_valid(vld[0]), .out_ready(out_ready), .out(res[0]),
        .cout(co[0]), .ovf(ov[0]));
    serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .a(a), .b(b),
        .control(control), .out_valid(vld[1]), .out_ready(out_ready), .out(res[1]),
        .cout(co[1]), .ovf(ov[1]));
    serial_add_sub #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .a(a), .b(b),
        .control(control), .out_valid(vld[2]), .out_ready(out_ready), .out(res[2]),
        .cout(co[2]), .ovf(ov[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plain 16-bit ripple reference: {cout, ovf, out}
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [15:0] yy;
        logic [16:0] full;
        logic [15:0] low;
        logic [15:0] r;
        logic        ovr;
        yy   = c ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {16'b0, c};
        low  = {1'b0, x[14:0]} + {1'b0, yy[14:0]} + {15'b0, c};
        ovr  = low[15] ^ full[16];
        r    = full[15:0];
`ifdef SERIAL_ADD_SUB_SAT_EN
        if (ovr) r = x[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {full[16], ovr, r};
    endfunction

    task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y, input logic c,
                          input logic [15:0] e_out, input logic e_co, input logic e_ov);
        bit seen [3];
        int lat;
        @(negedge clk);
        a = x; b = y; control = c; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; control = ~c;
        for (int i = 0; i < 3; i++) begin
            seen[i] = 1'b0;
            chk($sformatf("%s/d%0d/busy", tag, i), rdy[i], 0);
        end
        lat = 0;
        while (!(seen[0] && seen[1] && seen[2]) && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            for (int i = 0; i < 3; i++) begin
                if (!seen[i] && vld[i]) begin
                    seen[i] = 1'b1;
                    chk($sformatf("%s/d%0d/lat", tag, i), lat, lat_exp[i]);
                    chk($sformatf("%s/d%0d/out", tag, i), res[i], e_out);
                    chk($sformatf("%s/d%0d/cout", tag, i), co[i], e_co);
                    chk($sformatf("%s/d%0d/ovf", tag, i), ov[i], e_ov);
                end
            end
        end
        for (int i = 0; i < 3; i++)
            if (!seen[i]) chk($sformatf("%s/d%0d/timeout", tag, i), 0, 1);
    endtask

    task automatic settle(input string tag);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s/d%0d/idle_rdy", tag, i), rdy[i], 1);
            chk($sformatf("%s/d%0d/idle_vld", tag, i), vld[i], 0);
        end
    endtask

    initial begin
        logic [17:0] m;
        logic [15:0] rx, ry;
        logic        rc;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; control = 1'b0; out_ready = 1'b1;
        #12;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset/d%0d/rdy", i), rdy[i], 1);
            chk($sformatf("reset/d%0d/vld", i), vld[i], 0);
            chk($sformatf("reset/d%0d/out", i), res[i], 0);
            chk($sformatf("reset/d%0d/cout", i), co[i], 0);
            chk($sformatf("reset/d%0d/ovf", i), ov[i], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add1", 16'h1234, 16'h0FF0, 1'b0, 16'h2224, 1'b0, 1'b0);
        settle("add1");
        run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        settle("sub_neg");
        run_op("sub_pos", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
        settle("sub_pos");
`ifdef SERIAL_ADD_SUB_SAT_EN
        run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        settle("add_ovf");
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1);
        settle("sub_ovf");
`else
        run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        settle("add_ovf");
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        settle("sub_ovf");
`endif
        run_op("add_max", 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0);
        settle("add_max");

        // Backpressure: hold results, ignore a new request while in DONE
        out_ready = 1'b0;
        run_op("bp", 16'h1234, 16'h0FF0, 1'b0, 16'h2224, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'h4444; b = 16'h1111; control = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("bp%0d/d%0d/vld", k, i), vld[i], 1);
                chk($sformatf("bp%0d/d%0d/rdy", k, i), rdy[i], 0);
                chk($sformatf("bp%0d/d%0d/out", k, i), res[i], 16'h2224);
            end
        end
        out_ready = 1'b1;
        settle("bp_release");
        for (int i = 0; i < 3; i++)
            chk($sformatf("bp_hold/d%0d/out", i), res[i], 16'h2224);
        run_op("after_bp", 16'h0100, 16'h0001, 1'b1, 16'h00FF, 1'b1, 1'b0);
        settle("after_bp");

        // Reset while the DIGIT=4 instance is at count 2
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; control = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midrst/d%0d/vld", i), vld[i], 0);
            chk($sformatf("midrst/d%0d/rdy", i), rdy[i], 1);
            chk($sformatf("midrst/d%0d/out", i), res[i], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 16'h3000, 16'h0456, 1'b0, 16'h3456, 1'b0, 1'b0);
        settle("after_rst");

        for (int t = 0; t < 10; t++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            m  = model(rx, ry, rc);
            run_op($sformatf("rnd%0d", t), rx, ry, rc, m[15:0], m[17], m[16]);
            settle($sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
